text_line_scheduler: RTL and testbench

Shares one `font_rom` among up to `NUM_CHARS` on-screen character cells. It prefetches each text line's glyph rows into a small line buffer during horizontal blanking. The pixel path then reads only the buffer. This replaces per-digit ROM instances in the score/high-score overlays. It sits between the VGA controller (`drawX`/`drawY`) and the color mapper, producing a single `to_color` text bit.

---
 rtl/text_pkg.sv | 19 +
 rtl/text_line_scheduler.sv | 132 +++++++++++++
 tb/tb_text_line_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants and fetch FSM state type for the text strip
package text_pkg;

  localparam int CODE_W   = 6;
  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 16;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/text_line_scheduler.sv
// rtl/text_line_scheduler.sv - prefetches one line of glyph rows per hblank from a shared font ROM
module text_line_scheduler
  import text_pkg::*;
#(
  parameter int NUM_CHARS = 8,
  parameter int TEXT_X0   = 24,
  parameter int TEXT_Y0   = 0,
  parameter int ROM_LAT   = 0
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [9:0]                  drawX,
  input  logic [9:0]                  drawY,
  input  logic [CODE_W*NUM_CHARS-1:0] char_codes,
  output logic [9:0]                  rom_addr,
  input  logic [7:0]                  rom_data,
  output logic                        fetch_busy,
  output logic                        to_color
);

  localparam logic [9:0] X0      = 10'(TEXT_X0);
  localparam logic [9:0] Y0      = 10'(TEXT_Y0);
  localparam logic [9:0] STRIP_W = 10'(GLYPH_W * NUM_CHARS);
  localparam logic [9:0] STRIP_H = 10'(GLYPH_H);
  localparam logic [9:0] LINE_GO = 10'(H_ACTIVE);
  localparam logic [9:0] VB_LINE = 10'(V_ACTIVE);
  localparam logic [9:0] LAST_Y  = 10'(V_TOTAL - 1);
  localparam logic [4:0] LAST_I  = 5'(NUM_CHARS - 1);

  fetch_state_t state, state_nx;

  logic [9:0] prev_x, prev_y;
  logic [5:0] snap    [32];
  logic [7:0] linebuf [32];
  logic [4:0] idx;
  logic [3:0] row;
  logic       cap_valid;
  logic [4:0] cap_idx;

  logic       line_start, snap_entry, next_in_win, pixel;
  logic [9:0] next_y, next_off, dx, dy;

  assign line_start = (drawX == LINE_GO) && (prev_x != LINE_GO);
  assign snap_entry = (drawY == VB_LINE) && (prev_y != VB_LINE);
  assign next_y     = (drawY == LAST_Y) ? 10'd0 : drawY + 10'd1;

  // Offsets wrap to large values when below the origin, so one unsigned compare covers both edges.
  assign next_off    = next_y - Y0;
  assign next_in_win = next_off < STRIP_H;
  assign dx          = drawX - X0;
  assign dy          = drawY - Y0;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    rom_addr   = '0;
    fetch_busy = 1'b0;
    case (state)
      IDLE: begin
        if (line_start && next_in_win) state_nx = FETCH;
      end
      FETCH: begin
        fetch_busy = 1'b1;
        rom_addr   = {snap[idx], row};
        if (idx == LAST_I) state_nx = (ROM_LAT == 1) ? DRAIN : IDLE;
      end
      DRAIN: begin
        fetch_busy = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pixel = 1'b0;
    if (dy < STRIP_H && dx < STRIP_W) pixel = linebuf[dx[7:3]][3'd7 - dx[2:0]];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_x    <= '0;
      prev_y    <= '0;
      idx       <= '0;
      row       <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      to_color  <= 1'b0;
      for (int k = 0; k < 32; k++) begin
        snap[k]    <= '0;
        linebuf[k] <= '0;
      end
    end else begin
      prev_x    <= drawX;
      prev_y    <= drawY;
      cap_valid <= 1'b0;
      to_color  <= pixel;

      if (snap_entry) begin
        for (int k = 0; k < NUM_CHARS; k++) snap[k] <= char_codes[CODE_W*k +: CODE_W];
      end

      case (state)
        IDLE: begin
          idx <= '0;
          if (line_start) begin
            if (next_in_win) row <= next_off[3:0];
            else for (int k = 0; k < 32; k++) linebuf[k] <= '0;
          end
        end
        FETCH: begin
          idx <= idx + 5'd1;
          // A registered ROM returns this address's row one cycle later, so remember where it lands.
          if (ROM_LAT == 0) begin
            linebuf[idx] <= rom_data;
          end else begin
            cap_valid <= 1'b1;
            cap_idx   <= idx;
          end
        end
        default: ;
      endcase

      if (cap_valid) linebuf[cap_idx] <= rom_data;
    end
  end

endmodule

// File: tb/tb_text_line_scheduler.sv
// tb/tb_text_line_scheduler.sv - scoreboard bench over a combinational-ROM and a registered-ROM instance
module tb_text_line_scheduler;

  localparam int NC   = 8;
  localparam int X0   = 24;
  localparam int Y0_A = 0;
  localparam int Y0_B = 100;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [9:0]      drawX, drawY;
  logic [6*NC-1:0] char_codes;
  logic [9:0]      rom_addr_a, rom_addr_b;
  logic [7:0]      rom_data_a, rom_data_b;
  logic            busy_a, busy_b, color_a, color_b;

  always #5 Clk = ~Clk;

  function automatic logic [7:0] glyph(input logic [5:0] code, input logic [3:0] row);
    return {code[3:0], row} ^ {row, code[5:2]} ^ 8'h5a;
  endfunction

  assign rom_data_a = glyph(rom_addr_a[9:4], rom_addr_a[3:0]);
  always @(posedge Clk) rom_data_b <= glyph(rom_addr_b[9:4], rom_addr_b[3:0]);

  text_line_scheduler #(.NUM_CHARS(NC), .TEXT_X0(X0), .TEXT_Y0(Y0_A), .ROM_LAT(0)) u_dut_a (
    .Clk(Clk), .Reset(Reset), .drawX(drawX), .drawY(drawY), .char_codes(char_codes),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .fetch_busy(busy_a), .to_color(color_a)
  );

  text_line_scheduler #(.NUM_CHARS(NC), .TEXT_X0(X0), .TEXT_Y0(Y0_B), .ROM_LAT(1)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .drawX(drawX), .drawY(drawY), .char_codes(char_codes),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .fetch_busy(busy_b), .to_color(color_b)
  );

  logic [5:0] m_snap [NC];
  logic [7:0] m_lb   [2][NC];
  logic [9:0] m_px, m_py;
  logic [9:0] aq_a[$], aq_b[$];
  logic       pq_a[$], pq_b[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aq_a.delete(); aq_b.delete(); pq_a.delete(); pq_b.delete();
    for (int k = 0; k < NC; k++) begin
      m_snap[k]  = '0;
      m_lb[0][k] = '0;
      m_lb[1][k] = '0;
    end
    m_px = '0;
    m_py = '0;
  endtask

  task automatic set_codes(input logic [5:0] c0, input logic [5:0] c1, input logic [5:0] base);
    for (int k = 0; k < NC; k++)
      char_codes[6*k +: 6] = (k == 0) ? c0 : (k == 1) ? c1 : 6'(base + 6'(k));
  endtask

  task automatic tick(input logic [9:0] x, input logic [9:0] y);
    int       y0, ny, xi, yi, dxi;
    logic     pix;
    logic [3:0] row;
    drawX = x;
    drawY = y;
    xi = int'(x);
    yi = int'(y);
    for (int n = 0; n < 2; n++) begin
      y0  = (n == 0) ? Y0_A : Y0_B;
      pix = 1'b0;
      if (yi >= y0 && yi < y0 + 16 && xi >= X0 && xi < X0 + 8*NC) begin
        dxi = xi - X0;
        pix = m_lb[n][dxi / 8][7 - (dxi % 8)];
      end
      if (n == 0) pq_a.push_back(pix);
      else        pq_b.push_back(pix);
    end
    if (yi == 480 && m_py != 10'd480)
      for (int k = 0; k < NC; k++) m_snap[k] = char_codes[6*k +: 6];
    if (xi == 640 && m_px != 10'd640) begin
      ny = (yi == 524) ? 0 : yi + 1;
      for (int n = 0; n < 2; n++) begin
        y0 = (n == 0) ? Y0_A : Y0_B;
        if (ny >= y0 && ny < y0 + 16) begin
          row = 4'(ny - y0);
          for (int k = 0; k < NC; k++) begin
            if (n == 0) aq_a.push_back({m_snap[k], row});
            else        aq_b.push_back({m_snap[k], row});
            m_lb[n][k] = glyph(m_snap[k], row);
          end
          if (n == 1) aq_b.push_back(10'd0);
        end else begin
          for (int k = 0; k < NC; k++) m_lb[n][k] = '0;
        end
      end
    end
    m_px = x;
    m_py = y;
    @(posedge Clk);
    #1;
    chk("pix_a", 32'(color_a), 32'(pq_a.pop_front()));
    chk("pix_b", 32'(color_b), 32'(pq_b.pop_front()));
    if (busy_a) begin
      if (aq_a.size() != 0) chk("addr_a", 32'(rom_addr_a), 32'(aq_a.pop_front()));
      else                  chk("busy_a_extra", 32'(busy_a), 32'd0);
    end else begin
      chk("addr_a_idle", 32'(rom_addr_a), 32'd0);
    end
    if (busy_b) begin
      if (aq_b.size() != 0) chk("addr_b", 32'(rom_addr_b), 32'(aq_b.pop_front()));
      else                  chk("busy_b_extra", 32'(busy_b), 32'd0);
    end else begin
      chk("addr_b_idle", 32'(rom_addr_b), 32'd0);
    end
  endtask

  task automatic line_end_check();
    chk("pending_a", 32'(aq_a.size()), 32'd0);
    chk("pending_b", 32'(aq_b.size()), 32'd0);
    aq_a.delete();
    aq_b.delete();
  endtask

  task automatic run_line(input int y);
    for (int x = 16; x < 100; x++)  tick(10'(x), 10'(y));
    for (int x = 630; x < 664; x++) tick(10'(x), 10'(y));
    line_end_check();
  endtask

  task automatic run_lines(input int lo, input int hi);
    for (int y = lo; y <= hi; y++) run_line(y);
  endtask

  initial begin
    Reset      = 1'b1;
    drawX      = '0;
    drawY      = '0;
    char_codes = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy_a",  32'(busy_a),     32'd0);
    chk("rst_addr_a",  32'(rom_addr_a), 32'd0);
    chk("rst_color_a", 32'(color_a),    32'd0);
    chk("rst_busy_b",  32'(busy_b),     32'd0);
    chk("rst_addr_b",  32'(rom_addr_b), 32'd0);
    chk("rst_color_b", 32'(color_b),    32'd0);
    Reset = 1'b0;

    // Frame 1: code-0 glyphs on screen, digits '1','2' captured at vblank.
    set_codes(6'h31, 6'h32, 6'h08);
    run_lines(0, 16);
    run_lines(98, 116);
    run_lines(478, 482);
    run_lines(523, 524);

    // Frame 2: digits shown; a mid-frame code change must wait for vblank.
    run_lines(0, 4);
    set_codes(6'h20, 6'h21, 6'h10);
    run_lines(5, 16);
    run_lines(98, 116);
    run_lines(478, 482);
    run_lines(523, 524);

    // Frame 3: reset while cell 3 is on the ROM address bus.
    run_lines(0, 2);
    for (int x = 16; x < 100; x++)  tick(10'(x), 10'd3);
    for (int x = 630; x < 644; x++) tick(10'(x), 10'd3);
    chk("cell3_busy", 32'(busy_a), 32'd1);
    drawX = 10'd644;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("midrst_busy_a",  32'(busy_a),     32'd0);
    chk("midrst_addr_a",  32'(rom_addr_a), 32'd0);
    chk("midrst_color_a", 32'(color_a),    32'd0);
    chk("midrst_busy_b",  32'(busy_b),     32'd0);
    chk("midrst_addr_b",  32'(rom_addr_b), 32'd0);
    Reset = 1'b0;
    model_reset();
    for (int x = 645; x < 664; x++) tick(10'(x), 10'd3);
    line_end_check();
    run_lines(4, 16);
    run_lines(98, 116);
    set_codes(6'h3f, 6'h00, 6'h18);
    run_lines(478, 482);
    run_lines(523, 524);

    // Frame 4: third code set.
    run_lines(0, 16);
    run_lines(98, 116);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
